// File: rtl/conv2d_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_mac_engine
//  Description : Sequential valid-mode (stride 1, no padding) 2-D convolution
//                processing element. One signed multiply-accumulate per clock,
//                results written into a registered output activation buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_mac_engine #(
    parameter int MAX_INPUT_DIM  = 15,
    parameter int MAX_KERNEL_DIM = 7,
    parameter int DATABUS_WIDTH  = 32
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     start,
    output logic                                                     done,
    input  logic [$clog2(MAX_INPUT_DIM)-1:0]                         input_width,
    input  logic [$clog2(MAX_INPUT_DIM)-1:0]                         input_height,
    input  logic [$clog2(MAX_INPUT_DIM)-1:0]                         kernel_size,
    input  logic [MAX_KERNEL_DIM*MAX_KERNEL_DIM*DATABUS_WIDTH-1:0]   local_kernel,
    input  logic [MAX_INPUT_DIM*MAX_INPUT_DIM*DATABUS_WIDTH-1:0]     local_activation_in,
    output logic [MAX_INPUT_DIM*MAX_INPUT_DIM*DATABUS_WIDTH-1:0]     local_activation_out
);

    localparam int CW = $clog2(MAX_INPUT_DIM);
    localparam int KW = $clog2(MAX_KERNEL_DIM);
    localparam int DW = DATABUS_WIDTH;

    localparam logic [CW-1:0] c_MAX_K = CW'(MAX_KERNEL_DIM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_MAC   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [CW-1:0]          r_w;
    logic [CW-1:0]          r_h;
    logic [CW-1:0]          r_k;
    logic [CW-1:0]          r_ox;
    logic [CW-1:0]          r_oy;
    logic [KW-1:0]          r_i;
    logic [KW-1:0]          r_j;
    logic signed [DW-1:0]   r_acc;
    logic                   r_done;
    logic signed [DW-1:0]   r_out [MAX_INPUT_DIM][MAX_INPUT_DIM];

    logic signed [DW-1:0]   w_act [MAX_INPUT_DIM][MAX_INPUT_DIM];
    logic signed [DW-1:0]   w_ker [MAX_KERNEL_DIM][MAX_KERNEL_DIM];
    logic [CW-1:0]          w_row;
    logic [CW-1:0]          w_col;
    logic [CW-1:0]          w_km1;
    logic [CW-1:0]          w_ow_m1;
    logic [CW-1:0]          w_oh_m1;
    logic                   w_dims_ok;
    logic                   w_j_last;
    logic                   w_last_tap;
    logic                   w_last_pix;
    logic signed [DW-1:0]   w_prod;

    // Unpack the flattened buses into 2-D views and pack the result buffer.
    for (genvar r = 0; r < MAX_INPUT_DIM; r++) begin : g_act_row
        for (genvar c = 0; c < MAX_INPUT_DIM; c++) begin : g_act_col
            assign w_act[r][c] = local_activation_in[(r*MAX_INPUT_DIM+c)*DW +: DW];
            assign local_activation_out[(r*MAX_INPUT_DIM+c)*DW +: DW] = r_out[r][c];
        end
    end

    for (genvar r = 0; r < MAX_KERNEL_DIM; r++) begin : g_ker_row
        for (genvar c = 0; c < MAX_KERNEL_DIM; c++) begin : g_ker_col
            assign w_ker[r][c] = local_kernel[(r*MAX_KERNEL_DIM+c)*DW +: DW];
        end
    end

    // Kernels wider than the kernel buffer are treated like any other
    // impossible geometry so indices always stay inside the buffers.
    assign w_dims_ok  = (r_k != '0) && (r_k <= r_w) && (r_k <= r_h) && (r_k <= c_MAX_K);
    assign w_km1      = r_k - CW'(1);
    assign w_ow_m1    = r_w - r_k;
    assign w_oh_m1    = r_h - r_k;
    assign w_j_last   = (CW'(r_j) == w_km1);
    assign w_last_tap = w_j_last && (CW'(r_i) == w_km1);
    assign w_last_pix = (r_ox == w_ow_m1) && (r_oy == w_oh_m1);

    assign w_row  = r_oy + CW'(r_i);
    assign w_col  = r_ox + CW'(r_j);
    // Product truncated to the element width: wraps modulo 2^DW.
    assign w_prod = w_act[w_row][w_col] * w_ker[r_i][r_j];

    assign done = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = w_dims_ok ? ST_MAC : ST_IDLE;
            ST_MAC:   if (w_last_tap) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = w_last_pix ? ST_IDLE : ST_MAC;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: dimension latch, counters, accumulator and result buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w    <= '0;
            r_h    <= '0;
            r_k    <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
            for (int r = 0; r < MAX_INPUT_DIM; r++) begin
                for (int c = 0; c < MAX_INPUT_DIM; c++) begin
                    r_out[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_w    <= input_width;
                        r_h    <= input_height;
                        r_k    <= kernel_size;
                        r_done <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_ox  <= '0;
                    r_oy  <= '0;
                    r_i   <= '0;
                    r_j   <= '0;
                    r_acc <= '0;
                    for (int r = 0; r < MAX_INPUT_DIM; r++) begin
                        for (int c = 0; c < MAX_INPUT_DIM; c++) begin
                            r_out[r][c] <= '0;
                        end
                    end
                    if (!w_dims_ok) begin
                        r_done <= 1'b1;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (w_j_last) begin
                        r_j <= '0;
                        r_i <= r_i + KW'(1);
                    end else begin
                        r_j <= r_j + KW'(1);
                    end
                end
                ST_WRITE: begin
                    r_out[r_oy][r_ox] <= r_acc;
                    r_acc <= '0;
                    r_i   <= '0;
                    r_j   <= '0;
                    if (r_ox == w_ow_m1) begin
                        r_ox <= '0;
                        r_oy <= r_oy + CW'(1);
                    end else begin
                        r_ox <= r_ox + CW'(1);
                    end
                    if (w_last_pix) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2d_mac_engine
//  Description : Directed self-checking bench for conv2d_mac_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_mac_engine;

    localparam int MI = 15;
    localparam int MK = 7;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    done;
    logic [3:0]              input_width;
    logic [3:0]              input_height;
    logic [3:0]              kernel_size;
    logic [MK*MK*DW-1:0]     local_kernel;
    logic [MI*MI*DW-1:0]     local_activation_in;
    logic [MI*MI*DW-1:0]     local_activation_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv2d_mac_engine #(
        .MAX_INPUT_DIM  (MI),
        .MAX_KERNEL_DIM (MK),
        .DATABUS_WIDTH  (DW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .done                 (done),
        .input_width          (input_width),
        .input_height         (input_height),
        .kernel_size          (kernel_size),
        .local_kernel         (local_kernel),
        .local_activation_in  (local_activation_in),
        .local_activation_out (local_activation_out)
    );

    function automatic logic [DW-1:0] out_at(input int r, input int c);
        return local_activation_out[(r*MI+c)*DW +: DW];
    endfunction

    task automatic put_act(input int r, input int c, input logic [DW-1:0] v);
        local_activation_in[(r*MI+c)*DW +: DW] = v;
    endtask

    task automatic put_ker(input int r, input int c, input logic [DW-1:0] v);
        local_kernel[(r*MK+c)*DW +: DW] = v;
    endtask

    // 3x3 ones, 2x2 ones kernel.
    task automatic load_case1();
        local_activation_in = '0;
        local_kernel        = '0;
        input_width  = 4'd3;
        input_height = 4'd3;
        kernel_size  = 4'd2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                put_act(r, c, 32'd1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                put_ker(r, c, 32'd1);
    endtask

    // Issue one start and count edges until done; pulse start again at edge
    // number pulse_at after the start edge (0 = never).
    task automatic run_conv(input int pulse_at, output int cycles, output logic done_e0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        done_e0 = done;
        cycles  = 0;
        while (cycles < 200) begin
            @(negedge clk);
            start = (cycles + 1 == pulse_at);
            @(posedge clk);
            cycles++;
            #1;
            if (done === 1'b1) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        load_case1();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        n_cmp++;
        if (local_activation_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero buffer expected all 0");
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic(input int pulse_at, input string tag);
        int cyc;
        logic d0;
        logic [DW-1:0] exp_v;
        load_case1();
        run_conv(pulse_at, cyc, d0);
        n_cmp++;
        if (d0 !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done_cleared: got %b expected 0", tag, d0);
        end
        n_cmp++;
        if (cyc !== 21) begin
            n_err++;
            $display("FAIL %s_latency: got %0d expected 21", tag, cyc);
        end
        for (int r = 0; r < MI; r++) begin
            for (int c = 0; c < MI; c++) begin
                exp_v = (r < 2 && c < 2) ? 32'd4 : 32'd0;
                n_cmp++;
                if (out_at(r, c) !== exp_v) begin
                    n_err++;
                    $display("FAIL %s_out[%0d][%0d]: got %h expected %h", tag, r, c, out_at(r, c), exp_v);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || out_at(1, 1) !== 32'd4) begin
            n_err++;
            $display("FAIL %s_hold: got done=%b out11=%h expected done=1 out11=4", tag, done, out_at(1, 1));
        end
    endtask

    task automatic test_identity_4x4();
        int cyc;
        logic d0;
        logic [DW-1:0] exp_v;
        local_activation_in = '0;
        local_kernel        = '0;
        input_width  = 4'd4;
        input_height = 4'd4;
        kernel_size  = 4'd1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                put_act(r, c, 32'(r*4 + c));
        put_ker(0, 0, 32'd1);
        run_conv(0, cyc, d0);
        n_cmp++;
        if (cyc !== 33) begin
            n_err++;
            $display("FAIL ident_latency: got %0d expected 33", cyc);
        end
        for (int r = 0; r < MI; r++) begin
            for (int c = 0; c < MI; c++) begin
                exp_v = (r < 4 && c < 4) ? 32'(r*4 + c) : 32'd0;
                n_cmp++;
                if (out_at(r, c) !== exp_v) begin
                    n_err++;
                    $display("FAIL ident_out[%0d][%0d]: got %h expected %h", r, c, out_at(r, c), exp_v);
                end
            end
        end
    endtask

    task automatic test_signed_wrap(input logic [DW-1:0] a, input logic [DW-1:0] k,
                                    input logic [DW-1:0] exp_v, input string tag);
        int cyc;
        logic d0;
        local_activation_in = '0;
        local_kernel        = '0;
        input_width  = 4'd1;
        input_height = 4'd1;
        kernel_size  = 4'd1;
        put_act(0, 0, a);
        put_ker(0, 0, k);
        run_conv(0, cyc, d0);
        n_cmp++;
        if (cyc !== 3) begin
            n_err++;
            $display("FAIL %s_latency: got %0d expected 3", tag, cyc);
        end
        n_cmp++;
        if (out_at(0, 0) !== exp_v) begin
            n_err++;
            $display("FAIL %s_out00: got %h expected %h", tag, out_at(0, 0), exp_v);
        end
        n_cmp++;
        if (out_at(0, 1) !== 32'd0) begin
            n_err++;
            $display("FAIL %s_out01: got %h expected 0", tag, out_at(0, 1));
        end
    endtask

    task automatic test_degenerate();
        int cyc;
        logic d0;
        load_case1();
        kernel_size = 4'd4;
        run_conv(0, cyc, d0);
        n_cmp++;
        if (cyc !== 1) begin
            n_err++;
            $display("FAIL degen_latency: got %0d expected 1", cyc);
        end
        n_cmp++;
        if (local_activation_out !== '0) begin
            n_err++;
            $display("FAIL degen_outputs: got nonzero buffer (out00=%h) expected all 0", out_at(0, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        load_case1();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (out_at(0, 0) !== 32'd4) begin
            n_err++;
            $display("FAIL midrun_partial: got %h expected 4", out_at(0, 0));
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || local_activation_out !== '0) begin
            n_err++;
            $display("FAIL midrun_abort: got done=%b out00=%h expected done=0 out=0", done, out_at(0, 0));
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || out_at(0, 0) !== 32'd0) begin
            n_err++;
            $display("FAIL midrun_idle: got done=%b out00=%h expected done=0 out00=0", done, out_at(0, 0));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic d0;
        logic [DW-1:0] exp_v;
        test_basic(0, "b2b_first");
        // second data set: in[r][c]=r*3+c, kernel [[1,0],[0,-1]] -> all -4
        local_activation_in = '0;
        local_kernel        = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                put_act(r, c, 32'(r*3 + c));
        put_ker(0, 0, 32'd1);
        put_ker(1, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_drop: got %b expected 0", done);
        end
        @(posedge clk);
        #1;
        cyc = 1;
        n_cmp++;
        if (local_activation_out !== '0) begin
            n_err++;
            $display("FAIL b2b_cleared: got out00=%h expected all 0", out_at(0, 0));
        end
        while (cyc < 200 && done !== 1'b1) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        n_cmp++;
        if (cyc !== 21) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d expected 21", cyc);
        end
        for (int r = 0; r < MI; r++) begin
            for (int c = 0; c < MI; c++) begin
                exp_v = (r < 2 && c < 2) ? 32'hFFFF_FFFC : 32'd0;
                n_cmp++;
                if (out_at(r, c) !== exp_v) begin
                    n_err++;
                    $display("FAIL b2b_out[%0d][%0d]: got %h expected %h", r, c, out_at(r, c), exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_identity_4x4();
        test_signed_wrap(32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFA, "neg");
        test_signed_wrap(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, "wrap");
        test_degenerate();
        test_basic(5, "ignore_start");
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
